// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM encoding and default sizing.
package spi_pkg;

    localparam int CLK_DIV_DEF = 8;
    localparam int DATA_W_DEF  = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        WAIT_NEXT,
        HOLD,
        GAP
    } spi_state_e;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator for the SPI master.
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV + 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(CLK_DIV - 1));

    // Reloads on every tick, so it never runs past CLK_DIV-1.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master with multi-word frames, slave-select hold and gap.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic              SysClk,
    input  logic              Reset,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_last,
    output logic              tx_ready,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              SPI_CLK,
    output logic              SPI_MOSI,
    input  logic              SPI_MISO,
    output logic              SPI_SS
);

    localparam int BW = $clog2(DATA_W + 1);

    spi_state_e        state;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic [BW-1:0]     bit_cnt;
    logic              last_q;
    logic              tick;
    logic              accept;
    logic              div_en;

    assign accept   = tx_valid && tx_ready;
    assign busy     = (state != IDLE);
    assign div_en   = state inside {SETUP, SHIFT, HOLD, GAP};
    assign SPI_MOSI = tx_sr[DATA_W-1];

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk     (SysClk),
        .rst     (Reset),
        .en      (div_en),
        .restart (accept),
        .tick    (tick)
    );

    always_ff @(posedge SysClk) begin
        if (Reset) begin
            state    <= IDLE;
            SPI_SS   <= 1'b1;
            SPI_CLK  <= 1'b0;
            tx_ready <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            bit_cnt  <= '0;
            last_q   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            unique case (state)
                IDLE, WAIT_NEXT: begin
                    tx_ready <= 1'b1;
                    if (accept) begin
                        state    <= SETUP;
                        tx_ready <= 1'b0;
                        SPI_SS   <= 1'b0;
                        tx_sr    <= tx_data;
                        last_q   <= tx_last;
                        bit_cnt  <= '0;
                    end
                end
                SETUP: begin
                    if (tick) begin
                        state   <= SHIFT;
                        SPI_CLK <= 1'b1;
                        rx_sr   <= {rx_sr[DATA_W-2:0], SPI_MISO};
                        bit_cnt <= bit_cnt + BW'(1);
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (SPI_CLK) begin
                            SPI_CLK <= 1'b0;
                            // MOSI stays on the final bit after the last fall.
                            if (bit_cnt != BW'(DATA_W)) begin
                                tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
                            end
                        end else if (bit_cnt == BW'(DATA_W)) begin
                            rx_data  <= rx_sr;
                            rx_valid <= 1'b1;
                            tx_ready <= !last_q;
                            state    <= last_q ? HOLD : WAIT_NEXT;
                        end else begin
                            SPI_CLK <= 1'b1;
                            rx_sr   <= {rx_sr[DATA_W-2:0], SPI_MISO};
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        state  <= GAP;
                        SPI_SS <= 1'b1;
                    end
                end
                GAP: begin
                    if (tick) begin
                        state    <= IDLE;
                        tx_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed and randomized bench for spi_master with a bus-level model.
module tb_spi_master;

    localparam int CLK_DIV = 2;
    localparam int DATA_W  = 8;

    logic       SysClk = 1'b0;
    logic       Reset = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_last = 1'b0;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       busy;
    logic       SPI_CLK;
    logic       SPI_MOSI;
    logic       SPI_MISO;
    logic       SPI_SS;
    logic       miso_one = 1'b0;

    assign SPI_MISO = miso_one ? 1'b1 : SPI_MOSI;

    spi_master #(
        .CLK_DIV (CLK_DIV),
        .DATA_W  (DATA_W)
    ) dut (
        .SysClk   (SysClk),
        .Reset    (Reset),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_last  (tx_last),
        .tx_ready (tx_ready),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .busy     (busy),
        .SPI_CLK  (SPI_CLK),
        .SPI_MOSI (SPI_MOSI),
        .SPI_MISO (SPI_MISO),
        .SPI_SS   (SPI_SS)
    );

    always #5 SysClk = ~SysClk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge SysClk) cyc <= cyc + 1;

    int   rise_cnt = 0;
    int   ss_low_cnt = 0;
    int   ss_rise_cnt = 0;
    int   rxv_cnt = 0;
    int   ss_first = -1;
    int   rdy_rise = -1;
    bit   mosi_q[$];
    logic [7:0] rx_q[$];
    logic prev_sck = 1'b0;
    logic prev_ss = 1'b1;
    logic prev_rdy = 1'b0;

    always @(negedge SysClk) begin
        if (SPI_CLK === 1'b1 && prev_sck !== 1'b1) begin
            rise_cnt++;
            mosi_q.push_back(SPI_MOSI);
        end
        if (SPI_SS === 1'b0) begin
            ss_low_cnt++;
            if (ss_first < 0) ss_first = cyc;
        end
        if (SPI_SS === 1'b1 && prev_ss === 1'b0) ss_rise_cnt++;
        if (rx_valid === 1'b1) begin
            rxv_cnt++;
            rx_q.push_back(rx_data);
        end
        if (tx_ready === 1'b1 && prev_rdy !== 1'b1 && rdy_rise < 0)
            rdy_rise = cyc;
        prev_sck = SPI_CLK;
        prev_ss  = SPI_SS;
        prev_rdy = tx_ready;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        @(negedge SysClk);
        #2;
        rise_cnt = 0;
        ss_low_cnt = 0;
        ss_rise_cnt = 0;
        rxv_cnt = 0;
        ss_first = -1;
        rdy_rise = -1;
        mosi_q.delete();
        rx_q.delete();
    endtask

    function automatic logic [31:0] bits_at(input int off, input int n);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++)
            v = {v[30:0], (off + i < mosi_q.size()) ? mosi_q[off + i] : 1'b0};
        return v;
    endfunction

    function automatic logic [7:0] rx_at(input int i);
        return (i < rx_q.size()) ? rx_q[i] : 8'hxx;
    endfunction

    int acc_cyc = 0;

    task automatic send(input logic [7:0] d, input logic l);
        int n = 0;
        while (tx_ready !== 1'b1 && n < 500) begin
            @(negedge SysClk);
            #1;
            n++;
        end
        chk("send_ready_wait", (n < 500), 1);
        tx_valid = 1'b1;
        tx_data  = d;
        tx_last  = l;
        acc_cyc  = cyc;
        @(posedge SysClk);
        #1;
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(busy === 1'b0 && tx_ready === 1'b1) && n < 1000) begin
            @(negedge SysClk);
            #1;
            n++;
        end
        chk("idle_wait", (n < 1000), 1);
    endtask

    initial begin
        int a;
        int n;
        int bad;
        int r0;
        int nfr;
        int bit_bad;
        logic [7:0] exp_q[$];
        logic [7:0] d;

        repeat (3) @(negedge SysClk);
        #1;
        chk("rst_ss", SPI_SS, 1);
        chk("rst_sck", SPI_CLK, 0);
        chk("rst_mosi", SPI_MOSI, 0);
        chk("rst_rdy", tx_ready, 0);
        chk("rst_busy", busy, 0);
        Reset = 1'b0;
        @(negedge SysClk);
        #1;
        chk("rdy_after_rst", tx_ready, 1);

        // single word, loopback
        clr();
        miso_one = 1'b0;
        send(8'hA5, 1'b1);
        a = acc_cyc;
        wait_idle();
        chk("a5_rises", rise_cnt, 8);
        chk("a5_mosi", bits_at(0, 8), 32'hA5);
        chk("a5_ss_low", ss_low_cnt, 36);
        chk("a5_ss_first", ss_first, a + 1);
        chk("a5_rdy_back", rdy_rise, a + (2 * DATA_W + 3) * CLK_DIV + 1);
        chk("a5_rxv", rxv_cnt, 1);
        chk("a5_rx", rx_at(0), 8'hA5);

        // reset mid-idle
        repeat (3) @(negedge SysClk);
        #1;
        Reset = 1'b1;
        repeat (3) @(negedge SysClk);
        #1;
        chk("idle_rst_ss", SPI_SS, 1);
        chk("idle_rst_sck", SPI_CLK, 0);
        chk("idle_rst_mosi", SPI_MOSI, 0);
        chk("idle_rst_rx", rx_data, 0);
        chk("idle_rst_rdy", tx_ready, 0);
        Reset = 1'b0;
        @(negedge SysClk);
        #1;
        chk("idle_rst_rdy_back", tx_ready, 1);

        // back-to-back words, MISO high
        clr();
        miso_one = 1'b1;
        send(8'h3C, 1'b0);
        send(8'hC3, 1'b1);
        wait_idle();
        miso_one = 1'b0;
        chk("b2b_rises", rise_cnt, 16);
        chk("b2b_mosi", bits_at(0, 16), 32'h3CC3);
        chk("b2b_ss_rise", ss_rise_cnt, 1);
        chk("b2b_rxv", rxv_cnt, 2);
        chk("b2b_rx0", rx_at(0), 8'hFF);
        chk("b2b_rx1", rx_at(1), 8'hFF);

        // stall in WAIT_NEXT
        clr();
        send(8'h12, 1'b0);
        n = 0;
        while (rxv_cnt < 1 && n < 500) begin
            @(negedge SysClk);
            #1;
            n++;
        end
        chk("stall_first_word", rxv_cnt, 1);
        r0 = rise_cnt;
        bad = 0;
        repeat (100) begin
            @(negedge SysClk);
            #1;
            if (SPI_SS !== 1'b0 || SPI_CLK !== 1'b0 || tx_ready !== 1'b1)
                bad++;
        end
        chk("stall_violations", bad, 0);
        chk("stall_edges", rise_cnt - r0, 0);
        send(8'h34, 1'b1);
        wait_idle();
        chk("stall_mosi", bits_at(0, 16), 32'h1234);
        chk("stall_rx0", rx_at(0), 8'h12);
        chk("stall_rx1", rx_at(1), 8'h34);
        chk("stall_ss_rise", ss_rise_cnt, 1);

        // tx_valid pulse while shifting is ignored
        clr();
        send(8'h5A, 1'b1);
        n = 0;
        while (SPI_CLK !== 1'b1 && n < 500) begin
            @(negedge SysClk);
            #1;
            n++;
        end
        chk("ign_saw_shift", SPI_CLK, 1);
        tx_valid = 1'b1;
        tx_data  = 8'h77;
        tx_last  = 1'b1;
        @(posedge SysClk);
        #1;
        tx_valid = 1'b0;
        wait_idle();
        repeat (20) @(negedge SysClk);
        #1;
        chk("ign_busy", busy, 0);
        chk("ign_rises", rise_cnt, 8);
        chk("ign_mosi", bits_at(0, 8), 32'h5A);
        chk("ign_rxv", rxv_cnt, 1);
        chk("ign_rx", rx_at(0), 8'h5A);

        // reset at 5th rising edge aborts the frame
        clr();
        send(8'hFF, 1'b1);
        n = 0;
        while (rise_cnt < 5 && n < 500) begin
            @(negedge SysClk);
            #1;
            n++;
        end
        chk("abort_rises", rise_cnt, 5);
        Reset = 1'b1;
        @(negedge SysClk);
        #1;
        chk("abort_ss", SPI_SS, 1);
        chk("abort_sck", SPI_CLK, 0);
        Reset = 1'b0;
        repeat (5) @(negedge SysClk);
        #1;
        chk("abort_rxv", rxv_cnt, 0);
        chk("abort_busy", busy, 0);
        clr();
        send(8'h01, 1'b1);
        wait_idle();
        chk("post_abort_mosi", bits_at(0, 8), 32'h01);
        chk("post_abort_rx", rx_at(0), 8'h01);
        chk("post_abort_rxv", rxv_cnt, 1);
        chk("post_abort_ss_low", ss_low_cnt, 36);

        // randomized frames, loopback
        clr();
        exp_q.delete();
        for (int f = 0; f < 6; f++) begin
            nfr = $urandom_range(1, 3);
            for (int w = 0; w < nfr; w++) begin
                d = 8'($urandom);
                exp_q.push_back(d);
                send(d, (w == nfr - 1));
            end
            wait_idle();
        end
        chk("rand_words", rx_q.size(), exp_q.size());
        chk("rand_ss_frames", ss_rise_cnt, 6);
        chk("rand_rises", rise_cnt, 8 * exp_q.size());
        bit_bad = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (bits_at(8 * i, 8) !== {24'h0, exp_q[i]}) bit_bad++;
            chk($sformatf("rand_rx%0d", i), rx_at(i), exp_q[i]);
        end
        chk("rand_mosi_words", bit_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 8, meaning SysClk cycles per SPI_CLK half-period; legal range 1..255.
REQ-002 SHALL have parameter DATA_W, default 8, meaning bits per SPI word.
REQ-003 SysClk  input  1  single system clock, 300 MHz; all logic on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 tx_valid  input  1  host offers a word.
REQ-006 tx_data  input  DATA_W  word to shift out, MSB first.
REQ-007 tx_last  input  1  word ends the frame; SPI_SS deasserts after it.
REQ-008 tx_ready  output  1  block accepts a word this cycle.
REQ-009 rx_valid  output  1  one-cycle pulse: rx_data updated.
REQ-010 rx_data  output  DATA_W  last word captured from SPI_MISO.
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 SPI_CLK  output  1  serial clock, mode 0 (CPOL=0, CPHA=0).
REQ-013 SPI_MOSI  output  1  serial data out.
REQ-014 SPI_MISO  input  1  serial data in.
REQ-015 SPI_SS  output  1  active-low slave select.

Function
REQ-016 States SHALL be IDLE, SETUP, SHIFT, WAIT_NEXT, HOLD, GAP.
REQ-017 A word SHALL be accepted only on a cycle with tx_valid=1 and tx_ready=1; tx_ready=1 only in IDLE and WAIT_NEXT.
REQ-018 On acceptance at cycle t: tx_data and tx_last latched; state=SETUP at t+1; SPI_SS=0 and SPI_MOSI=bit DATA_W-1 from t+1.
REQ-019 SETUP SHALL last CLK_DIV cycles with SPI_CLK=0, then enter SHIFT.
REQ-020 SHIFT SHALL produce 2*DATA_W half-periods of CLK_DIV cycles each, starting high.
REQ-021 On each rising SPI_CLK transition, SPI_MISO SHALL be sampled on the same SysClk edge into the receive shift register; there is no synchronizer.
REQ-022 On each falling SPI_CLK transition except the last, SPI_MOSI SHALL advance to the next lower bit.
REQ-023 After the last low half-period: rx_data loaded; rx_valid=1 for exactly one cycle; next state=HOLD if the latched tx_last=1, else WAIT_NEXT.
REQ-024 WAIT_NEXT SHALL hold SPI_SS=0, SPI_CLK=0 and SPI_MOSI unchanged indefinitely until a word is accepted, which then enters SETUP.
REQ-025 HOLD SHALL last CLK_DIV cycles with SPI_SS=0; then GAP with SPI_SS=1 for CLK_DIV cycles; then IDLE.
REQ-026 Single-word frame timing: SPI_SS low from t+1 to t+(2*DATA_W+2)*CLK_DIV inclusive; tx_ready returns high at t+(2*DATA_W+3)*CLK_DIV+1.
REQ-027 tx_valid and tx_data SHALL be ignored when tx_ready=0; no queuing.
REQ-028 SPI_CLK SHALL be 0 in every state other than SHIFT.
REQ-029 The half-period counter SHALL be ceil(log2(CLK_DIV+1)) bits wide; the bit counter SHALL be ceil(log2(DATA_W+1)) bits wide; neither counter wraps.

Reset
REQ-030 While Reset=1 at a clock edge: state=IDLE, SPI_SS=1, SPI_CLK=0, SPI_MOSI=0, tx_ready=0, rx_valid=0, rx_data=0, busy=0, all counters 0.
REQ-031 tx_ready SHALL become 1 on the first cycle after Reset is sampled low.
REQ-032 Reset during a frame SHALL abort it: the partial word is discarded, no rx_valid pulse is produced, and the GAP state is skipped.

Structure
REQ-033 A shared package spi_pkg SHALL hold the state encoding and the CLK_DIV and DATA_W defaults.
REQ-034 One sub-module, spi_clk_div, SHALL generate the half-period tick; it has an enable and a synchronous restart.

Verification
REQ-035 Reset check: assert Reset for 3 cycles mid-idle -> SPI_SS=1, SPI_CLK=0, SPI_MOSI=0, rx_data=0, tx_ready=0; tx_ready=1 one cycle after release.
REQ-036 CLK_DIV=2, MISO looped to MOSI, send 0xA5 with tx_last=1 -> 8 rising edges carrying MOSI 1,0,1,0,0,1,0,1; SPI_SS low for exactly 36 cycles; rx_data=0xA5 with one rx_valid pulse.
REQ-037 Send 0x3C (last=0) then 0xC3 (last=1) back to back, MISO tied to 1 -> SPI_SS stays low across both words; 16 rising edges; two rx_valid pulses, each with rx_data=0xFF.
REQ-038 Send 0x12 (last=0) and hold tx_valid=0 for 100 cycles -> SPI_SS=0, SPI_CLK=0, no edges, tx_ready=1 throughout the 100 cycles.
REQ-039 Assert Reset at the 5th rising edge of a 0xFF frame -> SPI_SS=1 and SPI_CLK=0 on the next cycle with no rx_valid; a subsequent 0x01 frame completes correctly.
REQ-040 Pulse tx_valid with 0x77 while busy=1 in SHIFT -> word not transmitted and the current frame is unaffected.
